// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Streams 32-bit instruction words from a valid/ready source into an
// instruction memory, one word per accepted transfer, starting at address 0.
// The load ends when an end word is seen (top nibble == END_NIBBLE). It also
// ends if the memory fills up without an end word, which is an overflow.
//
// Parameters
//   ADDR_W      word-address width; memory depth is 2**ADDR_W words
//   END_NIBBLE  value of in_data[31:28] that marks the program end word
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   start       pulse; restarts a load from address 0 when in DONE or OVF
//   in_valid    in_data holds a valid word
//   in_data     instruction word, program order
//   in_ready    loader accepts in_data this cycle (high only while loading)
//   mem_we      memory write enable, one cycle after acceptance
//   mem_addr    memory word address of the write
//   mem_wdata   memory write data
//   load_done   program fully written, end word included
//   overflow    memory filled without an end word
//   word_count  number of words written in the current load
//   checksum    (only with INSTR_LOADER_CHECKSUM_EN) running 32-bit sum of
//               every written word, cleared by reset and by start
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to add the checksum port.
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int          ADDR_W     = 18,
  parameter logic [3:0]  END_NIBBLE = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              overflow,
`ifdef INSTR_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    OVF  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                load_done_q, load_done_d;
  logic                overflow_q, overflow_d;

  logic is_end;
  logic last_addr;

  assign is_end    = (in_data[31:28] == END_NIBBLE);
  assign last_addr = &ptr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_data;
          count_d     = count_q + (ADDR_W+1)'(1);
          // End word wins over overflow when both happen at the last address.
          if (is_end) begin
            state_d = DONE;
          end else if (last_addr) begin
            state_d = OVF;
          end
          // Saturate rather than wrap at the top of memory.
          if (!last_addr) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      DONE, OVF: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase

    load_done_d = (state_d == DONE);
    overflow_d  = (state_d == OVF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // The sum picks up a word on the same edge the memory stores it. A restart
  // clears the sum even if the final write of the previous load is on the bus.
  always_comb begin
    checksum_d = checksum_q + (mem_we_q ? mem_wdata_q : 32'd0);
    if ((state_q != LOAD) && start) begin
      checksum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign in_ready   = (state_q == LOAD);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Directed sequence followed by random traffic on a small (ADDR_W=2) loader.
// Expected behaviour comes from a transaction-level model: a load phase, the
// number of words taken so far, and the write that the last acceptance
// produced. It also keeps a running checksum when INSTR_LOADER_CHECKSUM_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] ENDW  = 32'hF000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          load_done;
  logic          overflow;
  logic [AW:0]   word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(AW), .END_NIBBLE(4'hF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_done  (load_done),
    .overflow   (overflow),
`ifdef INSTR_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .word_count (word_count)
  );

  // Model: phase 0 = loading, 1 = program complete, 2 = memory full
  int          m_phase;
  int          m_taken;
  logic        m_we;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_csum;
  logic        m_rst;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic rn, input logic st, input logic v, input logic [31:0] d);
    rst_n    = rn;
    start    = st;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    m_rst = !rn;
    if (!rn) begin
      m_phase = 0; m_taken = 0; m_we = 1'b0; m_addr = 0; m_wdata = '0; m_csum = '0;
    end else begin
      if (m_we) m_csum = m_csum + m_wdata;
      m_we = 1'b0;
      if (m_phase == 0 && v) begin
        m_we    = 1'b1;
        m_addr  = m_taken;
        m_wdata = d;
        m_taken = m_taken + 1;
        if (d[31:28] == 4'hF)       m_phase = 1;
        else if (m_taken == DEPTH)  m_phase = 2;
      end else if (m_phase != 0 && st) begin
        m_phase = 0; m_taken = 0; m_csum = '0;
      end
    end
    #1;
    if (m_we)
      $display("[%0t] write addr=%0d data=%h count=%0d", $time, m_addr, m_wdata, m_taken);
    check("in_ready",   64'(in_ready),   64'(m_phase == 0));
    check("mem_we",     64'(mem_we),     64'(m_we));
    if (m_we || m_rst) begin
      check("mem_addr",  64'(mem_addr),  64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check("load_done",  64'(load_done),  64'(m_phase == 1));
    check("overflow",   64'(overflow),   64'(m_phase == 2));
    check("word_count", 64'(word_count), 64'(m_taken));
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("checksum",   64'(checksum),   64'(m_csum));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic word(input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic pulse_start();
    step(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r_rn, r_st, r_v;
    logic [31:0] r_d;
    m_phase = 0; m_taken = 0; m_we = 1'b0; m_addr = 0; m_wdata = '0; m_csum = '0; m_rst = 1'b0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h1234_5678);

    // Back-to-back load ending with an end word
    word(32'h0000_0001);
    word(32'h0000_0002);
    word(ENDW);
    idle(2);
    check("done_after_three", 64'(word_count), 64'd3);

    // Restart, then words with gaps in in_valid
    pulse_start();
    word(32'h0000_0010);
    idle(2);
    word(32'h0000_0011);
    idle(1);
    word(ENDW | 32'h5);
    idle(1);

    // Fill memory without an end word -> overflow; valid stays high afterwards
    pulse_start();
    word(32'hA); word(32'hB); word(32'hC); word(32'hD);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 32'hE);
    check("ovf_flag", 64'(overflow), 64'd1);

    // Last-address end word -> done, not overflow
    pulse_start();
    word(32'h1); word(32'h2); word(32'h3); word(ENDW);
    idle(1);

    // Restart from done with a single end word
    pulse_start();
    word(ENDW);
    idle(1);

    // Start during a load is ignored; reset mid-load aborts it
    pulse_start();
    word(32'h1);
    step(1'b1, 1'b1, 1'b1, 32'h2);
    step(1'b0, 1'b0, 1'b1, 32'h3);
    word(32'h0000_0001);
    word(32'h0000_0002);
    word(ENDW);
    idle(2);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("checksum_after_reload", 64'(checksum), 64'h0000_0000_F000_0003);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_rn = ($urandom_range(0, 49) != 0);
      r_st = ($urandom_range(0, 7) == 0);
      r_v  = ($urandom_range(0, 2) != 0);
      r_d  = $urandom;
      if ($urandom_range(0, 5) == 0) r_d[31:28] = 4'hF;
      else if (r_d[31:28] == 4'hF)  r_d[31:28] = 4'h7;
      step(r_rn, r_st, r_v, r_d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 18, word-address width; instruction memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter END_NIBBLE, default 4'b1111, value of in_data[31:28] that marks the program end word.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; restarts a load from address 0 when in DONE or OVF.
REQ-006 in_valid  input  1  in_data holds a valid instruction word.
REQ-007 in_data  input  32  instruction word, in program order.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_we  output  1  instruction memory write enable.
REQ-010 mem_addr  output  ADDR_W  instruction memory word address.
REQ-011 mem_wdata  output  32  instruction memory write data.
REQ-012 load_done  output  1  program fully written, end word included; fetch may run.
REQ-013 overflow  output  1  memory filled without an end word.
REQ-014 word_count  output  ADDR_W+1  number of words written in the current load.

Function
REQ-015 States: LOAD, DONE, OVF; after reset the state is LOAD.
REQ-016 in_ready = 1 only in LOAD; a word is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-017 Write latency: one cycle; the cycle after acceptance, mem_we=1, mem_addr=write pointer, mem_wdata=accepted word; otherwise mem_we=0.
REQ-018 The write pointer starts at 0 and increments by 1 per accepted word; word_count increments with each write.
REQ-019 Accepting a word with in_data[31:28]==END_NIBBLE writes that word and moves the state to DONE; in_ready drops in the cycle following acceptance.
REQ-020 Accepting a non-end word at pointer 2^ADDR_W-1 writes it and moves the state to OVF; the pointer does not wrap.
REQ-021 A last-address word that is also an end word gives DONE, not OVF.
REQ-022 load_done = 1 exactly while in DONE; overflow = 1 exactly while in OVF; both are registered.
REQ-023 start in DONE or OVF: next state LOAD; pointer, word_count, load_done and overflow are cleared; memory contents are not cleared.
REQ-024 start in LOAD is ignored; the load continues unchanged.
REQ-025 in_valid=0 in LOAD: the loader waits indefinitely with no write.

Reset
REQ-026 rst_n=0 on a rising edge: state LOAD, pointer 0, word_count 0, mem_we 0, mem_addr 0, mem_wdata 0, load_done 0, overflow 0, and any pending write is discarded.
REQ-027 Reset during a load aborts it; the next accepted word is written to address 0.

Configuration
REQ-028 Macro INSTR_LOADER_CHECKSUM_EN defined: output checksum (32 bits) is added; it is cleared by reset and by start, and each write adds mem_wdata to it, modulo 2^32, in the same edge as the write.
REQ-029 Macro INSTR_LOADER_CHECKSUM_EN absent: the checksum port and its logic are not present; all other behaviour is identical.

Verification
REQ-030 Reset, then stream 0x00000001, 0x00000002, 0xF0000000 back-to-back -> writes to addresses 0,1,2 with those data, each one cycle after acceptance; load_done=1 after the third write; word_count=3; in_ready=0.
REQ-031 Gaps in in_valid between words -> no mem_we in gap cycles; addresses remain contiguous.
REQ-032 ADDR_W=2, stream four non-end words -> addresses 0..3 written, overflow=1, load_done=0, in_ready=0, word_count=4.
REQ-033 ADDR_W=2, fourth word 0xF0000000 -> load_done=1, overflow=0.
REQ-034 In DONE, pulse start, then stream 0xF0000000 -> write to address 0, word_count=1, load_done=1 again.
REQ-035 rst_n low for one cycle after two accepted words -> outputs at reset values; the next word is written to address 0; with INSTR_LOADER_CHECKSUM_EN, 0x1+0x2+0xF0000000 gives checksum 0xF0000003.
